// File: rtl/ram_sdp_init.sv
// Simple-dual-port synchronous RAM: one write port (per-bit mask) and one
// registered read port. Reads see writes to the same address in the same
// cycle. After reset, a sequencer fills every location with INIT_VAL before
// any request is accepted.
module ram_sdp_init #(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       ADDR_W   = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [DATA_W-1:0] wr_mask_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              ready_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_addr_q, init_addr_d;
  logic              ready_q, ready_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              init_last_c;
  logic              wr_fire_c;
  logic              rd_fire_c;
  logic              collide_c;
  logic [DATA_W-1:0] wr_merged_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_waddr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  // Requests only count once initialisation has finished.
  assign init_last_c = (init_addr_q == ADDR_W'(DEPTH - 1));
  assign wr_fire_c   = ready_q & wr_en_i;
  assign rd_fire_c   = ready_q & rd_en_i;
  assign collide_c   = wr_fire_c & rd_fire_c & (wr_addr_i == rd_addr_i);
  assign wr_merged_c = (mem_q[wr_addr_i] & ~wr_mask_i) | (wr_data_i & wr_mask_i);

  // Next-state, memory write port selection and read-port result.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    ready_d     = ready_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = wr_addr_i;
    mem_wdata_c = wr_merged_c;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    case (state_q)
      ST_INIT: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = init_addr_q;
        mem_wdata_c = INIT_VAL;
        init_addr_d = init_addr_q + ADDR_W'(1);
        if (init_last_c) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        mem_we_c = wr_fire_c;
        if (rd_fire_c) begin
          rd_valid_d = 1'b1;
          // Write-first: a same-address read returns the merged word.
          rd_data_d  = collide_c ? wr_merged_c : mem_q[rd_addr_i];
        end
      end
      default: begin
        state_d     = ST_INIT;
        init_addr_d = '0;
        ready_d     = 1'b0;
      end
    endcase
  end

  // Control and read-port registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      ready_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      ready_q     <= ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Storage array; never reset, the init sequencer overwrites it instead.
  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_we_c) begin
      mem_q[mem_waddr_c] <= mem_wdata_c;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign ready_o    = ready_q;

endmodule

// File: tb/tb_ram_sdp_init.sv
// Bench for ram_sdp_init (16x8, INIT_VAL=0): directed scenarios plus a
// randomized run, all checked against a behavioural RAM model.
module tb_ram_sdp_init;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] wr_mask;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       ready;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: array contents, init progress, last read result.
  logic [7:0] m_mem [16];
  bit         m_ready = 1'b0;
  int         m_cnt   = 0;
  logic [7:0] m_data  = 8'h00;
  bit         m_valid = 1'b0;

  ram_sdp_init #(
    .DATA_W  (8),
    .ADDR_W  (4),
    .INIT_VAL(8'h00)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .wr_mask_i (wr_mask),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data),
    .rd_valid_o(rd_valid),
    .ready_o   (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, step one edge, then advance the model.
  task automatic cycle(input bit r, input bit we, input logic [3:0] wa,
                       input logic [7:0] wd, input logic [7:0] wm,
                       input bit re, input logic [3:0] ra);
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd; wr_mask = wm;
    rd_en = re; rd_addr = ra;
    @(posedge clk);
    #1;
    if (r) begin
      m_ready = 1'b0; m_cnt = 0; m_valid = 1'b0; m_data = 8'h00;
    end else if (!m_ready) begin
      m_mem[m_cnt] = 8'h00;
      m_cnt++;
      if (m_cnt == 16) m_ready = 1'b1;
      m_valid = 1'b0;
    end else begin
      if (we) m_mem[wa] = (m_mem[wa] & ~wm) | (wd & wm);
      if (re) begin
        m_valid = 1'b1;
        m_data  = m_mem[ra];
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 4'h0);
  endtask

  task automatic test_reset();
    int n;
    cycle(1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 4'h0);
    cycle(1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 4'h0);
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", ready); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
    n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", rd_data); end
    n = 0;
    while (ready !== 1'b1 && n < 40) begin idle(); n++; end
    n_cmp++; if (n != 16) begin n_err++; $display("FAIL init_len got=%0d exp=16", n); end
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b1, 4'(i));
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h00)
        begin n_err++; $display("FAIL init_read[%0d] got=%b/%h exp=1/00", i, rd_valid, rd_data); end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i <= 12; i++) begin
      cycle(1'b0, 1'b1, 4'(i), 8'(25 + i), 8'hFF, 1'b0, 4'h0);
      n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL fill_idle_valid[%0d] got=%b exp=0", i, rd_valid); end
    end
    for (int i = 0; i <= 12; i++) begin
      cycle(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b1, 4'(i));
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(25 + i))
        begin n_err++; $display("FAIL fill_read[%0d] got=%b/%h exp=1/%h", i, rd_valid, rd_data, 8'(25 + i)); end
    end
    idle();
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL fill_after_valid got=%b exp=0", rd_valid); end
    n_cmp++; if (rd_data !== 8'd37) begin n_err++; $display("FAIL fill_hold got=%h exp=25", rd_data); end
  endtask

  task automatic test_mask();
    cycle(1'b0, 1'b1, 4'd3, 8'hA5, 8'hFF, 1'b0, 4'h0);
    cycle(1'b0, 1'b1, 4'd3, 8'hFF, 8'h0F, 1'b0, 4'h0);
    cycle(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b1, 4'd3);
    n_cmp++; if (rd_data !== 8'hAF) begin n_err++; $display("FAIL mask_merge got=%h exp=af", rd_data); end
    cycle(1'b0, 1'b1, 4'd3, 8'h00, 8'h00, 1'b0, 4'h0);
    cycle(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b1, 4'd3);
    n_cmp++; if (rd_data !== 8'hAF) begin n_err++; $display("FAIL mask_zero got=%h exp=af", rd_data); end
  endtask

  task automatic test_collision();
    cycle(1'b0, 1'b1, 4'd7, 8'h11, 8'hFF, 1'b0, 4'h0);
    cycle(1'b0, 1'b1, 4'd7, 8'h5A, 8'hFF, 1'b1, 4'd7);
    n_cmp++; if (rd_data !== 8'h5A || rd_valid !== 1'b1) begin n_err++; $display("FAIL collide_same got=%b/%h exp=1/5a", rd_valid, rd_data); end
    cycle(1'b0, 1'b1, 4'd7, 8'h11, 8'hFF, 1'b0, 4'h0);
    cycle(1'b0, 1'b1, 4'd8, 8'h33, 8'hFF, 1'b1, 4'd7);
    n_cmp++; if (rd_data !== 8'h11) begin n_err++; $display("FAIL collide_diff got=%h exp=11", rd_data); end
    cycle(1'b0, 1'b1, 4'd7, 8'hF0, 8'h3C, 1'b1, 4'd7);
    n_cmp++; if (rd_data !== 8'h31) begin n_err++; $display("FAIL collide_mask got=%h exp=31", rd_data); end
  endtask

  task automatic test_gating();
    int n;
    cycle(1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 4'h0);
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      cycle(1'b0, 1'b1, 4'd2, 8'h77, 8'hFF, 1'b1, 4'd2);
      n++;
      n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL gate_valid[%0d] got=%b exp=0", n, rd_valid); end
    end
    n_cmp++; if (n != 16) begin n_err++; $display("FAIL gate_init_len got=%0d exp=16", n); end
    cycle(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b1, 4'd2);
    n_cmp++; if (rd_data !== 8'h00 || rd_valid !== 1'b1) begin n_err++; $display("FAIL gate_read got=%b/%h exp=1/00", rd_valid, rd_data); end
  endtask

  task automatic test_reset_mid();
    int n;
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 4'(i), 8'hFF, 8'hFF, 1'b0, 4'h0);
    cycle(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b1, 4'd5);
    n_cmp++; if (rd_data !== 8'hFF || rd_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_read got=%b/%h exp=1/ff", rd_valid, rd_data); end
    cycle(1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 1'b1, 4'd6);
    n_cmp++; if (rd_valid !== 1'b0 || ready !== 1'b0) begin n_err++; $display("FAIL mid_rst got=%b/%b exp=0/0", rd_valid, ready); end
    n = 0;
    while (ready !== 1'b1 && n < 40) begin idle(); n++; end
    n_cmp++; if (n != 16) begin n_err++; $display("FAIL mid_init_len got=%0d exp=16", n); end
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b1, 4'(i));
      n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL mid_reinit[%0d] got=%h exp=00", i, rd_data); end
    end
    cycle(1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 4'h0);
    for (int i = 0; i < 9; i++) idle();
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL init9_ready got=%b exp=0", ready); end
    cycle(1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 4'h0);
    n = 0;
    while (ready !== 1'b1 && n < 40) begin idle(); n++; end
    n_cmp++; if (n != 16) begin n_err++; $display("FAIL init9_restart_len got=%0d exp=16", n); end
  endtask

  task automatic test_random();
    bit         we, re;
    logic [3:0] wa, ra;
    logic [7:0] wd, wm;
    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 3) != 0);
      wa = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      wd = 8'($urandom);
      wm = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      cycle(1'b0, we, wa, wd, wm, re, ra);
      n_cmp++;
      if (rd_valid !== m_valid || rd_data !== m_data || ready !== m_ready)
        begin n_err++; $display("FAIL rand[%0d] got=%b/%h/%b exp=%b/%h/%b", i, rd_valid, rd_data, ready, m_valid, m_data, m_ready); end
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    rd_en = 1'b0; rd_addr = '0;
    test_reset();
    test_fill();
    test_mask();
    test_collision();
    test_random();
    test_gating();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
